pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline sequencer for the 5-stage pipelined core (F, D, E, M, W).
- Merges hazard-unit requests (StallF, StallD, FlushD, FlushE) with two more sources:
  - multi-cycle data-memory wait in M;
  - debug halt/drain request.
- Produces the per-stage register enables and clears.
- Also keeps a sticky memory-timeout error and a saturating stall-cycle perf counter.

Parameters:
- DRAIN_CYCLES, 4: advancing cycles after fetch stops before the pipeline counts as empty.
- MEM_TIMEOUT, 64: maximum consecutive memory-wait cycles before forced release; must be >= 2.
- CNT_W, 16: width of stall_cnt.

Ports:
- clk  in  1  Rising-edge clock.
- reset_n  in  1  Asynchronous, active-low reset.
- StallF  in  1  Hazard unit: hold F.
- StallD  in  1  Hazard unit: hold D.
- FlushD  in  1  Hazard unit: bubble into D.
- FlushE  in  1  Hazard unit: bubble into E.
- MemReqM  in  1  Instruction in M is accessing data memory.
- MemReadyM  in  1  Data memory completes the access this cycle.
- halt_req  in  1  Level request: drain and halt.
- err_clr  in  1  Clears mem_err.
- perf_clr  in  1  Clears stall_cnt.
- EnF, EnD, EnE, EnM, EnW  out  1 each  Stage register enables.
- ClrD, ClrE, ClrW  out  1 each  Synchronous clear (bubble) of stage register; clear dominates enable.
- halted  out  1  State is HALTED.
- mem_err  out  1  Sticky: a memory timeout occurred.
- stall_cnt  out  CNT_W  Saturating count of cycles with EnF=0.

Behaviour:
- State machine: RUN, DRAIN, HALTED. The state register resets asynchronously to RUN.
- Outputs are combinational from state, counters and inputs.
- While reset_n=0:
  - all En* = 0, ClrD = ClrE = ClrW = 1;
  - halted = 0, mem_err = 0, stall_cnt = 0;
  - wait_cnt and drain_cnt = 0.
- wait_cnt is an internal counter of consecutive wait cycles, ceil(log2(MEM_TIMEOUT)) bits.
- Signal definitions:
  - tmo = (wait_cnt == MEM_TIMEOUT-1).
  - freeze = MemReqM & ~MemReadyM & ~tmo, evaluated in RUN and DRAIN only.
- freeze=1, in any non-HALTED state:
  - EnF = EnD = EnE = EnM = 0 and ClrD = ClrE = 0;
  - EnW = 1, ClrW = 1, so W receives a bubble and never double-writes;
  - hazard inputs are ignored;
  - wait_cnt increments.
- Timeout: when MemReqM & ~MemReadyM & tmo, the cycle is treated as ready. The pipeline advances, mem_err is set next edge, and wait_cnt clears.
- Any non-freeze cycle clears wait_cnt.
- RUN, no freeze:
  - EnF = ~StallF, EnD = ~StallD;
  - ClrD = FlushD, ClrE = FlushE;
  - EnE = EnM = EnW = 1, ClrW = 0.
- RUN to DRAIN: on halt_req=1 at the clock edge, including freeze cycles. drain_cnt clears.
- DRAIN, no freeze:
  - EnF = 0 (PC held; the fetched instruction is refetched later);
  - EnD = ~StallD, ClrD = FlushD | ~StallD;
  - ClrE = FlushE, EnE = EnM = EnW = 1.
- drain_cnt increments on DRAIN cycles with ~freeze & ~StallD.
- DRAIN to HALTED: when drain_cnt == DRAIN_CYCLES-1 and the cycle counts.
- DRAIN to RUN: halt_req=0 in DRAIN returns to RUN next cycle and drain_cnt clears. No instruction is lost.
- HALTED:
  - EnF = EnD = EnE = EnM = 0, ClrD = ClrE = 0;
  - EnW = 1, ClrW = 1;
  - halted = 1;
  - memory and hazard inputs are ignored;
  - on halt_req=0, go to RUN next cycle.
- mem_err: set on timeout. err_clr clears it; if set and clear coincide, set wins.
- stall_cnt:
  - increments each cycle EnF=0 in RUN or DRAIN (HALTED excluded);
  - saturates at all-ones;
  - perf_clr is synchronous and wins over increment.
- Async reset mid-DRAIN or mid-wait returns to RUN with all counters zero.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2);
  - default constants for DRAIN_CYCLES and MEM_TIMEOUT.
- One natural sub-module, sat_counter (width param, inc, clr, saturate), instantiated for stall_cnt.
- wait_cnt and drain_cnt stay inline.

Test Plan:
- RUN, StallF=1, StallD=1, FlushE=1, no memory -> EnF=0, EnD=0, ClrE=1, EnE/EnM/EnW=1, ClrW=0; stall_cnt increments by 1 per cycle.
- MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> 3 cycles of EnF..EnM=0, EnW=1, ClrW=1; 4th cycle all enables=1; mem_err stays 0.
- MEM_TIMEOUT=4, MemReadyM held 0 -> cycles 1-3 frozen, cycle 4 advances; mem_err=1 from the next cycle; err_clr=1 -> mem_err=0.
- halt_req=1 with no stalls -> DRAIN 4 cycles with EnF=0, ClrD=1; halted=1 on the 5th cycle; halt_req=0 -> RUN next cycle, EnF=1.
- DRAIN with StallD=1 for 2 cycles and one freeze cycle -> ClrD=0 and EnD=0 during StallD; HALTED reached after 4 counted cycles (7 total).
- stall_cnt forced near saturation (CNT_W=4, 20 stall cycles) -> holds 15; perf_clr together with a stall -> 0. reset_n low mid-DRAIN -> state RUN, outputs at reset values.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and default sizing for the pipeline sequencer.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pipeState_e;

    localparam int DEF_DRAIN_CYCLES = 4;
    localparam int DEF_MEM_TIMEOUT  = 64;
    localparam int DEF_CNT_W        = 16;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/memory requests into the sequencer and stage enables/clears out of it.
interface pipe_ctrl_if;

    logic StallF, StallD, FlushD, FlushE;
    logic MemReqM, MemReadyM;
    logic EnF, EnD, EnE, EnM, EnW;
    logic ClrD, ClrE, ClrW;

    modport master (
        output StallF, StallD, FlushD, FlushE, MemReqM, MemReadyM,
        input  EnF, EnD, EnE, EnM, EnW, ClrD, ClrE, ClrW
    );

    modport slave (
        input  StallF, StallD, FlushD, FlushE, MemReqM, MemReadyM,
        output EnF, EnD, EnE, EnM, EnW, ClrD, ClrE, ClrW
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && count != '1)
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges hazard, memory-wait and debug-halt requests into
// per-stage enables/clears; tracks memory timeouts and stalled fetch cycles.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    pipe_ctrl_if.slave       pif,
    input  logic             halt_req,
    input  logic             err_clr,
    input  logic             perf_clr,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W  = $clog2(MEM_TIMEOUT);
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    pipeState_e         state;
    logic [WAIT_W-1:0]  waitCnt;
    logic [DRAIN_W-1:0] drainCnt;

    logic active, memWait, tmo, freeze, timeout, drainStep, drainLast, stallInc;

    assign active    = (state != HALTED);
    assign memWait   = pif.MemReqM & ~pif.MemReadyM;
    assign tmo       = (waitCnt == WAIT_W'(MEM_TIMEOUT - 1));
    assign freeze    = active & memWait & ~tmo;
    // A stuck access is released as if ready so the core cannot hang forever.
    assign timeout   = active & memWait & tmo;
    assign drainStep = (state == DRAIN) & ~freeze & ~pif.StallD;
    assign drainLast = (drainCnt == DRAIN_W'(DRAIN_CYCLES - 1));
    assign stallInc  = reset_n & active & ~pif.EnF;

    always_comb begin
        // NOTE: every output gets a default first so no branch can infer a latch.
        pif.EnF  = 1'b0;
        pif.EnD  = 1'b0;
        pif.EnE  = 1'b0;
        pif.EnM  = 1'b0;
        pif.EnW  = 1'b0;
        pif.ClrD = 1'b0;
        pif.ClrE = 1'b0;
        pif.ClrW = 1'b0;
        if (!reset_n) begin
            pif.ClrD = 1'b1;
            pif.ClrE = 1'b1;
            pif.ClrW = 1'b1;
        end else if (!active || freeze) begin
            // W still clocks, but takes a bubble so the held M instruction writes once.
            pif.EnW  = 1'b1;
            pif.ClrW = 1'b1;
        end else if (state == DRAIN) begin
            pif.EnD  = ~pif.StallD;
            pif.ClrD = pif.FlushD | ~pif.StallD;
            pif.ClrE = pif.FlushE;
            pif.EnE  = 1'b1;
            pif.EnM  = 1'b1;
            pif.EnW  = 1'b1;
        end else begin
            pif.EnF  = ~pif.StallF;
            pif.EnD  = ~pif.StallD;
            pif.ClrD = pif.FlushD;
            pif.ClrE = pif.FlushE;
            pif.EnE  = 1'b1;
            pif.EnM  = 1'b1;
            pif.EnW  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RUN;
            halted   <= 1'b0;
            waitCnt  <= '0;
            drainCnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            waitCnt <= freeze ? waitCnt + WAIT_W'(1) : '0;

            if (timeout)
                mem_err <= 1'b1;
            else if (err_clr)
                mem_err <= 1'b0;

            case (state)
                RUN: begin
                    if (halt_req) begin
                        state    <= DRAIN;
                        drainCnt <= '0;
                    end
                end
                DRAIN: begin
                    if (!halt_req) begin
                        state    <= RUN;
                        drainCnt <= '0;
                    end else if (drainStep) begin
                        if (drainLast) begin
                            state    <= HALTED;
                            halted   <= 1'b1;
                            drainCnt <= '0;
                        end else begin
                            drainCnt <= drainCnt + DRAIN_W'(1);
                        end
                    end
                end
                HALTED: begin
                    if (!halt_req) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stallCnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (stallInc),
        .clr     (perf_clr),
        .count   (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and randomized checks of pipe_ctrl against a cycle-level reference model.
module tb_pipe_ctrl;

    localparam int DC  = 4;
    localparam int TMO = 4;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_HALT  = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          halt_req = 1'b0;
    logic          err_clr = 1'b0;
    logic          perf_clr = 1'b0;
    logic          halted, mem_err;
    logic [CW-1:0] stall_cnt;

    pipe_ctrl_if pif();

    pipe_ctrl #(.DRAIN_CYCLES(DC), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pif       (pif),
        .halt_req  (halt_req),
        .err_clr   (err_clr),
        .perf_clr  (perf_clr),
        .halted    (halted),
        .mem_err   (mem_err),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: abstract mode plus plain integer counters.
    int mMode  = M_RUN;
    int mWait  = 0;
    int mDrain = 0;
    int mStall = 0;
    bit mErr   = 1'b0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit memStuck();
        return pif.MemReqM && !pif.MemReadyM;
    endfunction

    function automatic bit modelFrozen();
        return (mMode != M_HALT) && memStuck() && (mWait < TMO - 1);
    endfunction

    // {EnF,EnD,EnE,EnM,EnW,ClrD,ClrE,ClrW,halted,mem_err}
    function automatic logic [9:0] expCtl();
        if (!reset_n)
            return 10'b00000_111_0_0;
        if (mMode == M_HALT || modelFrozen())
            return {4'b0000, 1'b1, 2'b00, 1'b1, mMode == M_HALT, mErr};
        if (mMode == M_DRAIN)
            return {1'b0, !pif.StallD, 3'b111, pif.FlushD || !pif.StallD, pif.FlushE, 1'b0, 1'b0, mErr};
        return {!pif.StallF, !pif.StallD, 3'b111, pif.FlushD, pif.FlushE, 1'b0, 1'b0, mErr};
    endfunction

    function automatic logic [9:0] obsCtl();
        return {pif.EnF, pif.EnD, pif.EnE, pif.EnM, pif.EnW,
                pif.ClrD, pif.ClrE, pif.ClrW, halted, mem_err};
    endfunction

    task automatic modelStep();
        bit live, frozen, timedOut, fetching;
        if (!reset_n) begin
            mMode = M_RUN; mWait = 0; mDrain = 0; mStall = 0; mErr = 1'b0;
            return;
        end
        live     = (mMode != M_HALT);
        frozen   = modelFrozen();
        timedOut = live && memStuck() && (mWait == TMO - 1);
        fetching = (mMode == M_RUN) && !frozen && !pif.StallF;

        if (perf_clr)               mStall = 0;
        else if (live && !fetching) mStall = (mStall < SAT) ? mStall + 1 : SAT;

        if (timedOut)     mErr = 1'b1;
        else if (err_clr) mErr = 1'b0;

        mWait = frozen ? mWait + 1 : 0;

        if (mMode == M_RUN) begin
            if (halt_req) begin mMode = M_DRAIN; mDrain = 0; end
        end else if (mMode == M_DRAIN) begin
            if (!halt_req) begin
                mMode = M_RUN; mDrain = 0;
            end else if (!frozen && !pif.StallD) begin
                mDrain++;
                if (mDrain == DC) begin mMode = M_HALT; mDrain = 0; end
            end
        end else if (!halt_req) begin
            mMode = M_RUN;
        end
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        check({tag, "/ctl"}, 16'(obsCtl()), 16'(expCtl()));
        check({tag, "/cnt"}, 16'(stall_cnt), reset_n ? 16'(mStall) : 16'd0);
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle($sformatf("%s%0d", tag, i));
    endtask

    task automatic setHaz(input bit sf, input bit sd, input bit fd, input bit fe);
        pif.StallF = sf; pif.StallD = sd; pif.FlushD = fd; pif.FlushE = fe;
    endtask

    task automatic setMem(input bit req, input bit rdy);
        pif.MemReqM = req; pif.MemReadyM = rdy;
    endtask

    initial begin
        setHaz(0, 0, 0, 0);
        setMem(0, 0);

        cycles(2, "reset");
        reset_n = 1'b1;

        setHaz(1, 1, 0, 1);
        cycles(3, "hazStall");
        setHaz(0, 0, 0, 0);

        setMem(1, 0);
        cycles(3, "memWait");
        setMem(1, 1);
        cycle("memReady");
        setMem(0, 0);

        setMem(1, 0);
        cycles(4, "memTmo");
        setMem(0, 0);
        check("memErrSet", 16'(mem_err), 16'd1);
        cycle("errHold");
        err_clr = 1'b1;
        cycle("errClr");
        err_clr = 1'b0;
        check("memErrCleared", 16'(mem_err), 16'd0);

        perf_clr = 1'b1;
        cycle("perfClr");
        perf_clr = 1'b0;
        halt_req = 1'b1;
        cycles(6, "drain");
        check("haltedAfterDrain", 16'(halted), 16'd1);
        halt_req = 1'b0;
        cycles(2, "resume");
        check("resumed", 16'(halted), 16'd0);

        halt_req = 1'b1;
        cycle("enterDrain");
        setHaz(0, 1, 0, 0);
        cycles(2, "drainStallD");
        setHaz(0, 0, 0, 0);
        setMem(1, 0);
        cycle("drainFreeze");
        setMem(0, 0);
        cycles(3, "drainCount");
        check("notYetHalted", 16'(halted), 16'd0);
        cycles(2, "drainLast");
        check("haltedAfterStalls", 16'(halted), 16'd1);
        halt_req = 1'b0;
        cycles(2, "resume2");

        setHaz(1, 0, 0, 0);
        cycles(20, "saturate");
        check("stallSaturated", 16'(stall_cnt), 16'(SAT));
        perf_clr = 1'b1;
        cycle("perfClrStall");
        perf_clr = 1'b0;
        check("stallCleared", 16'(stall_cnt), 16'd0);
        setHaz(0, 0, 0, 0);

        halt_req = 1'b1;
        cycles(3, "preReset");
        setMem(1, 0);
        cycles(2, "preResetWait");
        reset_n = 1'b0;
        cycle("midReset");
        check("resetHalted", 16'(halted), 16'd0);
        check("resetStall", 16'(stall_cnt), 16'd0);
        reset_n = 1'b1;
        halt_req = 1'b0;
        setMem(0, 0);
        cycles(2, "afterReset");

        for (int i = 0; i < 500; i++) begin
            setHaz($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            setMem($urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
            err_clr  = ($urandom_range(0, 19) == 0);
            perf_clr = ($urandom_range(0, 29) == 0);
            reset_n  = ($urandom_range(0, 149) != 0);
            cycle($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
